// File: rtl/oled_framebuffer.sv
// 96x64 RGB565 frame store feeding the SSD1331 scan core: registered pixel reads,
// host single-pixel writes and a full-frame clear engine, sharing one single-port RAM.
module oled_framebuffer #(
  parameter int unsigned C_x_size     = 96,
  parameter int unsigned C_y_size     = 64,
  parameter int unsigned C_color_bits = 16,
  parameter string       C_init_file  = ""
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [6:0]              x,
  input  logic [5:0]              y,
  input  logic                    next_pixel,
  output logic [C_color_bits-1:0] color,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [6:0]              wr_x,
  input  logic [5:0]              wr_y,
  input  logic [C_color_bits-1:0] wr_data,
  input  logic                    clr_start,
  input  logic [C_color_bits-1:0] clr_color,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned DEPTH = C_x_size * C_y_size;
  localparam int unsigned AW    = 13;
  localparam int unsigned CW    = C_color_bits;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            rd_pending_q, rd_pending_d;
  logic            rd_issue_q, rd_issue_d;
  logic            frame_done_q, frame_done_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]   clr_color_q, clr_color_d;
  logic [CW-1:0]   color_q, color_d;
  logic [CW-1:0]   ram_rdata_q;

  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_addr, scan_addr, wr_addr;
  logic [CW-1:0]   ram_wdata;
  logic            wr_in_range;

  logic [CW-1:0]   mem [DEPTH];

  // y*96 + x built from shifts so no multiplier is needed.
  assign scan_addr   = AW'({y, 6'b0}) + AW'({y, 5'b0}) + AW'(x);
  assign wr_addr     = AW'({wr_y, 6'b0}) + AW'({wr_y, 5'b0}) + AW'(wr_x);
  assign wr_in_range = (32'(wr_x) < C_x_size);

  // A pending read or a clear start in the same cycle blocks host writes.
  assign wr_ready   = (state_q == S_IDLE) & ~rd_pending_q & ~clr_start;
  assign color      = color_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    clr_cnt_d    = clr_cnt_q;
    clr_color_d  = clr_color_q;
    color_d      = color_q;
    rd_pending_d = rd_pending_q | next_pixel;
    rd_issue_d   = 1'b0;
    frame_done_d = next_pixel & (x == 7'd0) & (y == 6'd0);
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    if (rd_issue_q) color_d = ram_rdata_q;

    // Scan read has top priority and takes exactly one RAM cycle.
    if (rd_pending_q) begin
      ram_re       = 1'b1;
      ram_addr     = scan_addr;
      rd_pending_d = next_pixel;
      rd_issue_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d     = S_CLEAR;
          busy_d      = 1'b1;
          clr_cnt_d   = '0;
          clr_color_d = clr_color;
        end else if (wr_valid && wr_ready && wr_in_range) begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
      S_CLEAR: begin
        if (!rd_pending_q) begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt_q;
          ram_wdata = clr_color_q;
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      rd_pending_q <= 1'b1;
      rd_issue_q   <= 1'b0;
      frame_done_q <= 1'b0;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      rd_pending_q <= rd_pending_d;
      rd_issue_q   <= rd_issue_d;
      frame_done_q <= frame_done_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      color_q      <= color_d;
    end
  end

  // Single-port synchronous RAM, one access per cycle.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_oled_framebuffer.sv
// Randomised scoreboard bench for oled_framebuffer against a pixel-array reference model.
module tb_oled_framebuffer;

  localparam int XS   = 96;
  localparam int YS   = 64;
  localparam int NPIX = XS * YS;

  typedef struct packed {
    logic [15:0] col;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic        next_pixel = 1'b0;
  logic [15:0] color;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [6:0]  wr_x = '0;
  logic [5:0]  wr_y = '0;
  logic [15:0] wr_data = '0;
  logic        clr_start = 1'b0;
  logic [15:0] clr_color = '0;
  logic        busy;
  logic        frame_done;

  logic [15:0] mdl [NPIX];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;

  oled_framebuffer dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .next_pixel(next_pixel), .color(color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int pidx(input int px, input int py);
    return py * XS + px;
  endfunction

  function automatic logic [15:0] grad(input int px, input int py);
    return 16'(px * 683 + py * 1021 + 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Issue one scan position; x/y stay held until the next one.
  task automatic scan_px(input int px, input int py);
    exp_t e;
    e.col = mdl[pidx(px, py)];
    e.fd  = (px == 0 && py == 0);
    exp_q.push_back(e);
    x = 7'(px);
    y = 6'(py);
    next_pixel = 1'b1;
    @(negedge clk);
    next_pixel = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic host_write(input int px, input int py, input logic [15:0] d, output bit ok);
    int n;
    n = 0;
    wr_x = 7'(px);
    wr_y = 6'(py);
    wr_data = d;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (wr_ready === 1'b1);
    if (ok && px < XS) mdl[pidx(px, py)] = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic start_clear(input logic [15:0] c);
    clr_color = c;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 7000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: each next_pixel pops one expectation; frame_done one cycle later, colour three.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (next_pixel === 1'b1 && resetn === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          @(negedge clk);
          @(negedge clk);
          chk("color", 32'(color), 32'(e.col));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin
    bit ok;
    int n, cycles, acc, low, np_cnt, fd0, nbad;
    int wpx[100];
    int wpy[100];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    resetn = 1'b1;
    #1 chk("post_rst_wr_ready_pending", 32'(wr_ready), 32'h0);
    @(negedge clk);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);

    // Single write then fetch and hold
    host_write(5, 3, 16'hF800, ok);
    chk("wr_hs", 32'(ok), 32'h1);
    scan_px(5, 3);
    repeat (32) @(negedge clk);
    chk("hold_color", 32'(color), 32'hF800);

    // Full clear, no scan activity
    start_clear(16'h07E0);
    count_busy(n);
    chk("clear_busy_cycles", 32'(n), 32'd6144);
    for (int i = 0; i < NPIX; i++) mdl[i] = 16'h07E0;
    for (int i = 0; i < 8; i++) scan_px($urandom_range(XS - 1, 0), $urandom_range(YS - 1, 0));

    // Streaming writes (rows 32..63) with scan reads (rows 0..31) every 32 clocks
    cycles = 0; acc = 0; low = 0; np_cnt = 0;
    wpx[0] = $urandom_range(XS - 1, 0);
    wpy[0] = $urandom_range(YS - 1, 32);
    wr_x = 7'(wpx[0]); wr_y = 6'(wpy[0]); wr_data = 16'($urandom);
    wr_valid = 1'b1;
    while (acc < 100 && cycles < 1000) begin
      exp_t e;
      next_pixel = 1'b0;
      if (cycles % 32 == 5) begin
        x = 7'($urandom_range(XS - 1, 0));
        y = 6'($urandom_range(31, 0));
        e.col = mdl[pidx(int'(x), int'(y))];
        e.fd  = (x == 7'd0 && y == 6'd0);
        exp_q.push_back(e);
        next_pixel = 1'b1;
        np_cnt++;
      end
      ok = (wr_ready === 1'b1);
      if (ok) begin
        mdl[pidx(int'(wr_x), int'(wr_y))] = wr_data;
        acc++;
      end else begin
        low++;
      end
      cycles++;
      @(negedge clk);
      if (ok && acc < 100) begin
        wpx[acc] = $urandom_range(XS - 1, 0);
        wpy[acc] = $urandom_range(YS - 1, 32);
        wr_x = 7'(wpx[acc]); wr_y = 6'(wpy[acc]); wr_data = 16'($urandom);
      end
    end
    next_pixel = 1'b0;
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_writes_done", 32'(acc), 32'd100);
    chk("stream_ready_low", 32'(low), 32'(np_cnt));
    chk("stream_cycles", 32'(cycles), 32'(100 + np_cnt));
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(99, 0);
      scan_px(wpx[n], wpy[n]);
    end

    // Out-of-range column write completes but leaves RAM alone
    host_write(100, 0, 16'h1234, ok);
    chk("oob_hs", 32'(ok), 32'h1);
    scan_px(4, 1);

    // Gradient preload and full-frame scan ending on (0,0)
    nbad = 0;
    for (int py = 0; py < YS; py++)
      for (int px = 0; px < XS; px++) begin
        host_write(px, py, grad(px, py), ok);
        if (!ok) nbad++;
      end
    chk("fill_hs_timeouts", 32'(nbad), 32'h0);
    fd0 = fd_cnt;
    for (int k = 1; k <= NPIX; k++) scan_px((k % NPIX) % XS, (k % NPIX) / XS);
    repeat (2) @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt - fd0), 32'd1);

    // Reset in the middle of a clear, right after address 2999 is written
    clr_color = 16'hAAAA;
    clr_start = 1'b1;
    @(posedge clk);
    #1 clr_start = 1'b0;
    repeat (3000) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midclr_busy", 32'(busy), 32'h0);
    chk("midclr_color", 32'(color), 32'h0);
    for (int i = 0; i < 3000; i++) mdl[i] = 16'hAAAA;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    scan_px(2999 % XS, 2999 / XS);
    scan_px(3000 % XS, 3000 / XS);
    scan_px(0, 0);
    start_clear(16'h001F);
    count_busy(n);
    chk("reclear_busy_cycles", 32'(n), 32'd6144);
    for (int i = 0; i < NPIX; i++) mdl[i] = 16'h001F;
    scan_px(XS - 1, YS - 1);
    scan_px($urandom_range(XS - 1, 0), $urandom_range(YS - 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
